// File: rtl/debug_frame_pkg.sv
// debug_frame_pkg: shared constants, state encoding and command type for the debug frame decoder
package debug_frame_pkg;
  localparam logic [7:0] SYNC0_DEFAULT = 8'h5A;
  localparam logic [7:0] SYNC1_DEFAULT = 8'hA5;
  localparam int FRAME_PAYLOAD_BYTES = 4;
  typedef logic [$clog2(FRAME_PAYLOAD_BYTES)-1:0] pidx_t;
  typedef logic [4:0] state_t;
  localparam state_t S_SYNC0   = 5'b00001;
  localparam state_t S_SYNC1   = 5'b00010;
  localparam state_t S_PAYLOAD = 5'b00100;
  localparam state_t S_CHECK   = 5'b01000;
  localparam state_t S_HOLD    = 5'b10000;
  typedef struct packed {
    logic [7:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } debug_cmd_t;
endpackage

// File: rtl/debug_frame_timeout.sv
// debug_frame_timeout: saturating inter-byte counter, flags the last idle cycle before a frame is abandoned
module debug_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_reset,
  input  logic en,
  input  logic clr,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] MAX = W'(TIMEOUT_CYCLES);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (sync_reset || clr || !en) cnt <= '0;
    else if (cnt != MAX) cnt <= cnt + 1'b1;
  // a strobe in the expiry cycle suppresses the timeout
  assign expire = en && !clr && cnt == LAST;
endmodule

// File: rtl/debug_frame_decoder.sv
// debug_frame_decoder: hunts sync header, collects a checksummed debug command frame
// and holds the decoded command on a valid/ready handshake.
module debug_frame_decoder
  import debug_frame_pkg::*;
#(
  parameter logic [7:0] SYNC0 = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1 = SYNC1_DEFAULT,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sync_reset,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        chk_error_pulse,
  output logic        timeout_pulse,
  output logic        overrun_pulse
);
  state_t state;
  pidx_t idx;
  logic [7:0] acc;
  logic [FRAME_PAYLOAD_BYTES-1:0][7:0] pay;
  debug_cmd_t cmd;
  logic expire;
  logic counting;
  assign counting = |(state & (S_SYNC1 | S_PAYLOAD | S_CHECK));
  debug_frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .reset_n(reset_n),
    .sync_reset(sync_reset),
    .en(counting),
    .clr(rx_byte_valid),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_SYNC0;
      idx <= '0;
      acc <= '0;
      pay <= '0;
      cmd <= '0;
      chk_error_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      overrun_pulse <= 1'b0;
    end else if (sync_reset) begin
      state <= S_SYNC0;
      idx <= '0;
      acc <= '0;
      pay <= '0;
      cmd <= '0;
      chk_error_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      chk_error_pulse <= 1'b0;
      timeout_pulse <= 1'b0;
      overrun_pulse <= 1'b0;
      if (expire) begin
        timeout_pulse <= 1'b1;
        state <= S_SYNC0;
      end else if (state == S_HOLD) begin
        overrun_pulse <= rx_byte_valid;
        if (cmd_ready) state <= S_SYNC0;
      end else if (rx_byte_valid)
        case (state)
          S_SYNC0: if (rx_byte == SYNC0) state <= S_SYNC1;
          S_SYNC1: begin
            state <= rx_byte == SYNC1 ? S_PAYLOAD : rx_byte == SYNC0 ? S_SYNC1 : S_SYNC0;
            idx <= '0;
            acc <= '0;
          end
          S_PAYLOAD: begin
            pay[idx] <= rx_byte;
            acc <= acc ^ rx_byte;
            idx <= idx + 1'b1;
            if (idx == pidx_t'(FRAME_PAYLOAD_BYTES - 1)) state <= S_CHECK;
          end
          S_CHECK:
            if (rx_byte == acc) begin
              cmd <= '{typ: pay[0], addr: {pay[1], pay[2]}, data: pay[3]};
              state <= S_HOLD;
            end else begin
              chk_error_pulse <= 1'b1;
              state <= S_SYNC0;
            end
          default: state <= S_SYNC0;
        endcase
    end
  assign cmd_valid = state == S_HOLD;
  assign cmd_type = cmd.typ;
  assign cmd_addr = cmd.addr;
  assign cmd_data = cmd.data;
endmodule
